fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the in-order RV32 pipeline, directly upstream of the ID/EX pipeline register bank. Owns the architectural fetch PC and issues word requests to the instruction cache with a req/valid handshake. Presents instruction, PC and PC+4 to decode, and absorbs downstream stalls and EX-stage branch/jump redirects. Inserts bubbles on instruction-cache misses and redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_2000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction presented on bubbles and at reset (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low
- stall_in  in  1  downstream stall; when high, decode outputs hold
- redirect_valid  in  1  single-cycle pulse from EX; a taken branch or jump
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00)
- icache_req  out  1  fetch request
- icache_addr  out  32  word address of request
- icache_valid  in  1  response valid; may assert in the same cycle as req (zero-wait hit)
- icache_data  in  32  instruction word, valid with icache_valid
- inst_ID  out  32  instruction to decode
- PC_ID  out  32  PC of inst_ID
- PCplus4_ID  out  32  PC_ID + 4
- inst_valid_ID  out  1  0 = bubble
- fetch_miss_cycles  out  32  saturating count of cycles with icache_req & !icache_valid

## Operation
- State: pc_q (next fetch PC), addr_q (address of the outstanding request), skid buffer (inst, pc), FSM {IDLE, REQ, HOLD, KILL}.
- Transfer = icache_req & icache_valid at a posedge.
- Handshake: once icache_req rises, it and icache_addr stay stable until the transfer. There is no abort; a redirect never changes an outstanding address.
- IDLE: icache_req=0. Moves to REQ unconditionally at the next edge; addr_q=pc_q.
- REQ: icache_req=1, icache_addr=addr_q.
  - Transfer, no redirect, !stall_in: load the instruction to the decode outputs with valid=1; pc_q+=4; new request to pc_q+4 (back-to-back, no idle cycle); stay in REQ.
  - Transfer, no redirect, stall_in: write the skid buffer; go to HOLD.
  - No transfer, !stall_in: inst_valid_ID<=0 and inst_ID<=NOP_INST (bubble).
  - Redirect with transfer: discard the data; pc_q=addr_q=redirect_pc; stay in REQ.
  - Redirect without transfer: pc_q=redirect_pc; go to KILL.
- HOLD: icache_req=0.
  - When stall_in falls: skid buffer goes to the decode outputs; pc_q+=4; go to IDLE.
  - Redirect in HOLD: drop the skid buffer; pc_q=redirect_pc; go to IDLE.
- KILL: icache_req held with the old addr_q.
  - On transfer: discard the data; addr_q=pc_q; go to REQ.
  - A second redirect in KILL overwrites pc_q (last one wins).
- Redirect always has priority over a completing transfer. The decode outputs still obey stall_in: when a redirect occurs with !stall_in, the outputs become a bubble in the same edge.
- stall_in high: inst_ID, PC_ID, PCplus4_ID and inst_valid_ID hold their values in all states.
- Arithmetic: all PC math is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, with no flag. PCplus4_ID is always registered as PC_ID+4.
- fetch_miss_cycles increments each cycle with icache_req & !icache_valid, saturates at 32'hFFFF_FFFF and clears only on reset.

## Timing
- Reset (asynchronous assert): state=IDLE, pc_q=addr_q=RESET_PC, icache_req=0, icache_addr=RESET_PC, inst_ID=NOP_INST, PC_ID=RESET_PC-4 (32'h1FFC), PCplus4_ID=RESET_PC, inst_valid_ID=0, fetch_miss_cycles=0.
- Reset deassertion is synchronised by the system. icache_req rises after the first posedge following release.
- Reset mid-request drops the outstanding request silently. The icache must tolerate an abandoned request.
- Latency: zero-wait hit to decode output is 1 cycle after the request edge. Steady-state throughput is 1 instruction per cycle.
- Redirect penalty on a zero-wait hit: 1 bubble. With an outstanding miss: the remaining miss cycles plus 1.

## Structure
- The shared package riscv_pipe_pkg holds RESET_PC_DEFAULT, NOP_INST, and the fetch_state_t enum {IDLE, REQ, HOLD, KILL}.
- Single module, no submodules. The skid buffer is inline (one entry is sufficient because the request is not reissued in HOLD).

## Test plan
- Reset release with a zero-wait icache returning addr^32'hA5A5A5A5 -> first valid inst at PC_ID=0x2000, then 0x2004, 0x2008 on consecutive cycles, with no bubbles.
- Miss of 3 wait cycles at 0x2004 -> 3 bubbles with inst_ID=0x13 and inst_valid_ID=0, then 0x2004 delivered; fetch_miss_cycles=3.
- stall_in high for 4 cycles during a transfer at 0x2008 -> outputs frozen, icache_req=0 in HOLD; after release, 0x2008 is presented once, then fetch resumes at 0x200C with nothing lost or duplicated.
- redirect to 0x3001 during a 2-cycle miss at 0x200C -> req stays at 0x200C until valid, the data is discarded, the next request is 0x3000, and inst_valid_ID shows only bubbles until 0x3000.
- redirect to 0xFFFFFFFC with zero-wait hits -> PC_ID sequence 0xFFFFFFFC, 0x00000000; PCplus4_ID=0x00000000 for the first.
- Reset asserted mid-miss -> all outputs return to their reset values immediately; after release, fetch restarts at 0x2000.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants and fetch FSM states
package riscv_pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        KILL
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction fetch: PC ownership, icache req/valid handshake, skid and redirect handling
module fetch_stage #(
    parameter logic [31:0] RESET_PC = riscv_pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = riscv_pipe_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic [31:0] inst_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] PCplus4_ID,
    output logic        inst_valid_ID,
    output logic [31:0] fetch_miss_cycles
);
    import riscv_pipe_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  skid_inst_q, skid_inst_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_id_q, pc_id_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic [31:0]  miss_q, miss_d;
    logic         xfer;
    logic [31:0]  redir_tgt;

    assign icache_req        = (state_q == REQ) || (state_q == KILL);
    assign icache_addr       = addr_q;
    assign xfer              = icache_req & icache_valid;
    assign redir_tgt         = redirect_pc & ~32'd3;

    assign inst_ID           = inst_q;
    assign PC_ID             = pc_id_q;
    assign PCplus4_ID        = pc4_q;
    assign inst_valid_ID     = valid_q;
    assign fetch_miss_cycles = miss_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        inst_d      = inst_q;
        pc_id_d     = pc_id_q;
        valid_d     = valid_q;

        // Unstalled decode sees a bubble unless a delivery below overrides it
        if (!stall_in) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                addr_d  = pc_q;
                if (redirect_valid) begin
                    pc_d   = redir_tgt;
                    addr_d = redir_tgt;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    if (xfer) addr_d  = redir_tgt;
                    else      state_d = KILL;
                end else if (xfer) begin
                    if (stall_in) begin
                        skid_inst_d = icache_data;
                        skid_pc_d   = addr_q;
                        state_d     = HOLD;
                    end else begin
                        inst_d  = icache_data;
                        pc_id_d = addr_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        addr_d  = pc_q + 32'd4;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = IDLE;
                end else if (!stall_in) begin
                    inst_d  = skid_inst_q;
                    pc_id_d = skid_pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = IDLE;
                end
            end
            KILL: begin
                // The stale request must complete before the new target is issued
                if (redirect_valid) pc_d = redir_tgt;
                if (xfer) begin
                    addr_d  = redirect_valid ? redir_tgt : pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        pc4_d  = pc_id_d + 32'd4;
        miss_d = miss_q;
        if (icache_req && !icache_valid && (miss_q != 32'hFFFF_FFFF)) miss_d = miss_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_id_q     <= RESET_PC - 32'd4;
            pc4_q       <= RESET_PC;
            valid_q     <= 1'b0;
            miss_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            inst_q      <= inst_d;
            pc_id_q     <= pc_id_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            miss_q      <= miss_d;
        end
    end

endmodule
